// File: rtl/switch_csdf.sv
// switch_csdf: cyclo-static dataflow SWITCH actor.
// Each firing pops one select token from the control FIFO, then one data token
// from the data FIFO, then writes the data token to the output FIFO chosen by
// the select. Inputs face FIFO read sides and outputs face FIFO write sides.
// Optional build macro SWITCH_CSDF_ERRCNT_EN adds an 8-bit saturating err_cnt
// output. It counts data tokens dropped because their select was out of range.
//
// state   | meaning
// S_SEL   | phase 0: pop a select token when the control FIFO is not empty
// S_DATA  | phase 1: pop the data token; drop it if the select was out of range
// S_WRITE | phase 2: write the data token to the selected port once it has room
module switch_csdf #(
  parameter int WIDTH = 8,
  parameter int PORTS = 2,
  parameter int SELW  = $clog2(PORTS)
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic [1:0]             in_empty,
  output logic [1:0]             in_read,
  input  logic [WIDTH-1:0]       in_sel,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [PORTS-1:0]       out_full,
  output logic [PORTS-1:0]       out_wr,
  output logic [PORTS*WIDTH-1:0] out_data
`ifdef SWITCH_CSDF_ERRCNT_EN
  ,
  output logic [7:0]             err_cnt
`endif
);

  typedef enum logic [1:0] {
    S_SEL   = 2'd0,
    S_DATA  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  // Widened by one bit so the range check covers the full token width
  localparam logic [WIDTH:0] LP_PORTS = (WIDTH+1)'(PORTS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SELW-1:0]  r_sel;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  logic             w_sel_in_range;
  logic             w_pop_sel;
  logic             w_pop_data;
  logic             w_dst_full;
  logic [PORTS-1:0] w_dst_onehot;

  // Range check uses the whole select token, not just the bits kept in r_sel
  assign w_sel_in_range = ({1'b0, in_sel} < LP_PORTS);

  // Decode the latched select into a one-hot destination mask
  always_comb begin
    w_dst_onehot = '0;
    for (int k = 0; k < PORTS; k++) begin
      if (r_sel == SELW'(k)) begin
        w_dst_onehot[k] = 1'b1;
      end
    end
  end

  // Only the destination port's full flag can stall the write
  assign w_dst_full = |(w_dst_onehot & out_full);

  // Next-state and strobe logic. The strobes follow the current-cycle flags.
  // Reset suppresses every strobe so that no handshake completes.
  always_comb begin
    w_state_nxt = r_state;
    in_read     = '0;
    out_wr      = '0;
    w_pop_sel   = 1'b0;
    w_pop_data  = 1'b0;
    if (!rst) begin
      case (r_state)
        S_SEL: begin
          w_pop_sel  = ~in_empty[0];
          in_read[0] = ~in_empty[0];
          if (w_pop_sel) begin
            w_state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          w_pop_data = ~in_empty[1];
          in_read[1] = ~in_empty[1];
          if (w_pop_data) begin
            w_state_nxt = r_valid ? S_WRITE : S_SEL;
          end
        end
        S_WRITE: begin
          out_wr = w_dst_onehot & ~out_full;
          if (!w_dst_full) begin
            w_state_nxt = S_SEL;
          end
        end
        default: begin
          w_state_nxt = S_SEL;
        end
      endcase
    end
  end

  // State register plus the latched select and data tokens.
  // A reset in mid-firing discards both tokens.
  always_ff @(posedge ck) begin
    if (rst) begin
      r_state <= S_SEL;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop_sel) begin
        r_sel   <= in_sel[SELW-1:0];
        r_valid <= w_sel_in_range;
      end
      if (w_pop_data) begin
        r_data <= in_data;
      end
    end
  end

  // Every slot carries the latched data; out_wr alone marks which slot is live
  assign out_data = {PORTS{r_data}};

`ifdef SWITCH_CSDF_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // Count tokens dropped for an out-of-range select, saturating at 255
  always_ff @(posedge ck) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_pop_data && !r_valid && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule
